// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter
// Four requesters share one bitwise gate unit (AND / OR / XOR / NOR).
// A round-robin arbiter in IDLE grants one requester. Its operands are
// latched on the grant edge, evaluated in EXEC, and presented in RESP until
// the downstream handshake completes.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   req        per-requester request bits
//   req_a      packed operand A, requester i at [i*DW +: DW]
//   req_b      packed operand B, same packing as req_a
//   req_op     packed opcode, requester i at [2i+1:2i]
//   gnt        one-hot grant (combinational, IDLE only)
//   rsp_valid  result available (RESP state)
//   rsp_ready  downstream accepts result
//   rsp_id     index of the requester owning the result
//   rsp_data   gate result
//   busy       FSM is not in IDLE
module gate_op_arbiter #(
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] req_a,
    input  logic [4*DW-1:0] req_b,
    input  logic [7:0]      req_op,
    output logic [3:0]      gnt,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [1:0]      rsp_id,
    output logic [DW-1:0]   rsp_data,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    state_t          state_reg, state_next;
    logic [1:0]      ptr_reg;
    logic [DW-1:0]   lat_a_reg, lat_b_reg;
    logic [1:0]      lat_op_reg;
    logic [1:0]      lat_id_reg;
    logic [DW-1:0]   rsp_data_reg;
    logic [1:0]      rsp_id_reg;

    logic [DW-1:0]   a_arr   [4];
    logic [DW-1:0]   b_arr   [4];
    logic [1:0]      op_arr  [4];
    logic [1:0]      cand_idx[4];
    logic [1:0]      grant_idx;
    logic            grant_any;
    logic [3:0]      gnt_next;
    logic [DW-1:0]   gate_result;

    // Unpack the per-requester fields, and list the candidates in search
    // order: cand_idx[0] = ptr+1 (highest priority) ... cand_idx[3] = ptr.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign a_arr[gi]    = req_a[gi*DW +: DW];
            assign b_arr[gi]    = req_b[gi*DW +: DW];
            assign op_arr[gi]   = req_op[2*gi +: 2];
            assign cand_idx[gi] = ptr_reg + 2'(gi + 1);
        end
    endgenerate

    // Walk from lowest to highest priority so the last hit (highest
    // priority) wins. Reset forces the grant off even though it is
    // combinational.
    always_comb begin
        grant_idx = ptr_reg;
        grant_any = 1'b0;
        gnt_next  = '0;
        if (state_reg == IDLE && !reset) begin
            for (int k = 3; k >= 0; k--) begin
                if (req[cand_idx[k]]) begin
                    grant_idx = cand_idx[k];
                    grant_any = 1'b1;
                end
            end
        end
        if (grant_any) begin
            gnt_next[grant_idx] = 1'b1;
        end
    end

    // Bitwise gate unit on the latched operands.
    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_gate
            assign gate_result[gi] =
                (lat_op_reg == OP_AND) ? (lat_a_reg[gi] & lat_b_reg[gi]) :
                (lat_op_reg == OP_OR)  ? (lat_a_reg[gi] | lat_b_reg[gi]) :
                (lat_op_reg == OP_XOR) ? (lat_a_reg[gi] ^ lat_b_reg[gi]) :
                                         ~(lat_a_reg[gi] | lat_b_reg[gi]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= 2'd3;   // requester 0 searched first after reset
            lat_a_reg    <= '0;
            lat_b_reg    <= '0;
            lat_op_reg   <= '0;
            lat_id_reg   <= '0;
            rsp_data_reg <= '0;
            rsp_id_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_any) begin
                ptr_reg    <= grant_idx;
                lat_a_reg  <= a_arr[grant_idx];
                lat_b_reg  <= b_arr[grant_idx];
                lat_op_reg <= op_arr[grant_idx];
                lat_id_reg <= grant_idx;
            end
            // Result registers only load in EXEC, so they hold through RESP
            // and keep their value after the handshake.
            if (state_reg == EXEC) begin
                rsp_data_reg <= gate_result;
                rsp_id_reg   <= lat_id_reg;
            end
        end
    end

    assign gnt       = gnt_next;
    assign rsp_valid = (state_reg == RESP);
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_gate_op_arbiter.sv
module tb_gate_op_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_op;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    gate_op_arbiter #(.DW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_operands(input int id, input logic [3:0] a,
                                input logic [3:0] b, input logic [1:0] op);
        req_a[id*4 +: 4] = a;
        req_b[id*4 +: 4] = b;
        req_op[id*2 +: 2] = op;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 4'b1111;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_valid_busy got valid=%b busy=%b exp 0/0", rsp_valid, busy);
        end
        checks++;
        if (rsp_data !== 4'b0000 || rsp_id !== 2'd0) begin
            failures++; $display("FAIL reset_data_id got data=%b id=%0d exp 0000/0", rsp_data, rsp_id);
        end
        tick();
        req = 4'b0000;
        reset = 1'b0;
        #1;
        $display("txn reset: gnt=%b valid=%b busy=%b", gnt, rsp_valid, busy);
    endtask

    // Issue one operation from requester id and check grant, latency and result.
    // Operands are scrambled right after the grant edge; the result must not change.
    task automatic do_op(input int id, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] exp, input string name);
        logic [3:0] exp_gnt;
        bit got;
        exp_gnt = 4'b0001 << id;
        set_operands(id, a, b, op);
        rsp_ready = 1'b1;
        req = exp_gnt;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (gnt != 4'b0000) got = 1;
            else tick();
        end
        checks++;
        if (!got || gnt !== exp_gnt) begin
            failures++; $display("FAIL %s_gnt got=%b exp=%b", name, gnt, exp_gnt);
        end
        tick();
        req = 4'b0000;
        req_a = ~req_a;
        req_b = ~req_b;
        req_op = ~req_op;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || gnt !== 4'b0000) begin
            failures++; $display("FAIL %s_exec got valid=%b busy=%b gnt=%b exp 0/1/0000", name, rsp_valid, busy, gnt);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_id !== 2'(id)) begin
            failures++; $display("FAIL %s_rsp got valid=%b data=%b id=%0d exp 1/%b/%0d", name, rsp_valid, rsp_data, rsp_id, exp, id);
        end
        $display("txn %s: id=%0d op=%b a=%b b=%b data=%b", name, id, op, a, b, rsp_data);
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== exp) begin
            failures++; $display("FAIL %s_after got valid=%b busy=%b data=%b exp 0/0/%b", name, rsp_valid, busy, rsp_data, exp);
        end
    endtask

    task automatic test_single();
        do_op(0, 2'b10, 4'b1100, 4'b1010, 4'b0110, "single");
    endtask

    task automatic test_opcodes();
        do_op(1, 2'b00, 4'b1100, 4'b1010, 4'b1000, "op_and");
        do_op(2, 2'b01, 4'b1100, 4'b1010, 4'b1110, "op_or");
        do_op(3, 2'b10, 4'b1100, 4'b1010, 4'b0110, "op_xor");
        do_op(0, 2'b11, 4'b1100, 4'b1010, 4'b0001, "op_nor");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_operands(i, 4'(i), 4'b0000, 2'b01);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            #1;
            checks++;
            if (gnt !== exp_gnt) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, gnt, exp_gnt); end
            tick();
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_data !== 4'(k % 4)) begin
                failures++; $display("FAIL rr_rsp%0d got valid=%b id=%0d data=%b exp 1/%0d/%b", k, rsp_valid, rsp_id, rsp_data, k % 4, 4'(k % 4));
            end
            $display("txn rr%0d: gnt=%b id=%0d data=%b", k, exp_gnt, rsp_id, rsp_data);
            tick();
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_skip();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_op(0, 2'b00, 4'b1111, 4'b1111, 4'b1111, "skip_pre");
        set_operands(3, 4'b0101, 4'b0011, 2'b10);
        set_operands(0, 4'b0101, 4'b0011, 2'b00);
        req = 4'b1001;
        #1;
        checks++;
        if (gnt !== 4'b1000) begin failures++; $display("FAIL skip_gnt3 got=%b exp=1000", gnt); end
        tick();
        tick();
        checks++;
        if (rsp_id !== 2'd3 || rsp_data !== 4'b0110) begin
            failures++; $display("FAIL skip_rsp3 got id=%0d data=%b exp 3/0110", rsp_id, rsp_data);
        end
        tick();
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL skip_gnt0 got=%b exp=0001", gnt); end
        $display("txn skip: second gnt=%b", gnt);
        tick();
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_operands(0, 4'b0011, 4'b0101, 2'b01);
        rsp_ready = 1'b0;
        req = 4'b1111;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL bp_gnt got=%b exp=0001", gnt); end
        tick();
        set_operands(0, 4'b0000, 4'b0000, 2'b00);
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 4'b0111 || rsp_id !== 2'd0 || gnt !== 4'b0000 || busy !== 1'b1) begin
                failures++; $display("FAIL bp_hold%0d got valid=%b data=%b id=%0d gnt=%b busy=%b exp 1/0111/0/0000/1", c, rsp_valid, rsp_data, rsp_id, gnt, busy);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0010) begin
            failures++; $display("FAIL bp_release got valid=%b busy=%b gnt=%b exp 0/0/0010", rsp_valid, busy, gnt);
        end
        $display("txn backpressure: data=%b released gnt=%b", rsp_data, gnt);
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_in_resp();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_operands(2, 4'b1111, 4'b0000, 2'b00);
        rsp_ready = 1'b0;
        req = 4'b0100;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin failures++; $display("FAIL rr_resp_gnt got=%b exp=0100", gnt); end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rst_resp_valid got=%b exp=1", rsp_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
            failures++; $display("FAIL rst_resp_drop got valid=%b busy=%b gnt=%b exp 0/0/0000", rsp_valid, busy, gnt);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin failures++; $display("FAIL rst_resp_regnt got=%b exp=0100", gnt); end
        req = 4'b1111;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL rst_resp_tie got=%b exp=0001", gnt); end
        $display("txn reset_in_resp: tie gnt=%b", gnt);
        req = 4'b0000;
        rsp_ready = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_opcodes();
        test_round_robin();
        test_skip();
        test_backpressure();
        test_reset_in_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
